// File: rtl/arb_pkg.sv
// Shared types for the 2:1 bus arbiter: FSM state and requesting-port identifiers.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

endpackage

// File: rtl/bus_arbiter_2to1.sv
// 2:1 bus arbiter sharing one master port between an instruction and a data requester.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port wins ties.
module bus_arbiter_2to1
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,

    input  logic                  d_cyc,
    input  logic                  d_stb,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,

    output logic                  m_cyc,
    output logic                  m_stb,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ack
);

    logic       req_i;
    logic       req_d;
    arb_state_e state_q;
    arb_state_e state_d;
    arb_port_e  winner;

    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;

`ifdef ARB_ROUND_ROBIN_EN
    arb_port_e last_grant_q;
    arb_port_e last_grant_d;

    // On a tie the port that did not win last time goes first.
    function automatic arb_port_e sel_port(input logic ri, input logic rd, input arb_port_e last);
        if (ri && rd)
            return (last == PORT_I) ? PORT_D : PORT_I;
        else if (ri)
            return PORT_I;
        else
            return PORT_D;
    endfunction
`else
    function automatic arb_port_e sel_port(input logic ri, input logic rd);
        if (ri && !rd)
            return PORT_I;
        else
            return PORT_D;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        winner  = PORT_D;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
                    winner       = sel_port(req_i, req_d, last_grant_q);
                    last_grant_d = winner;
`else
                    winner       = sel_port(req_i, req_d);
`endif
                    state_d = (winner == PORT_I) ? GNT_I : GNT_D;
                end
            end
            // Completion or abort (requester dropped cyc) both release the bus.
            GNT_I: if (m_ack || !i_cyc) state_d = IDLE;
            GNT_D: if (m_ack || !d_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= PORT_D;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        case (state_q)
            GNT_I: begin
                m_cyc   = i_cyc;
                m_stb   = i_stb;
                m_we    = i_we;
                m_addr  = i_addr;
                m_wdata = i_wdata;
                i_ack   = m_ack;
            end
            GNT_D: begin
                m_cyc   = d_cyc;
                m_stb   = d_stb;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                d_ack   = m_ack;
            end
            default: ;
        endcase
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_bus_arbiter_2to1;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cyc, i_stb, i_we;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata, i_rdata;
    logic          i_ack;
    logic          d_cyc, d_stb, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          d_ack;
    logic          m_cyc, m_stb, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_ack;

    int checks = 0;
    int errors = 0;
    int owner  = 0;   // 0: bus free, 1: instruction port owns it, 2: data port owns it
    int last   = 2;   // last port granted (round-robin memory)
    int iack_cnt = 0;

    always #5 clk = ~clk;

    bus_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ack(i_ack),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ic, input logic is, input logic iw, input logic [AW-1:0] ia,
                       input logic dc, input logic ds, input logic dw, input logic [AW-1:0] da,
                       input logic ack, input logic [DW-1:0] rd);
        i_cyc = ic; i_stb = is; i_we = iw; i_addr = ia; i_wdata = ia ^ 32'h5A5A_0000;
        d_cyc = dc; d_stb = ds; d_we = dw; d_addr = da; d_wdata = da ^ 32'h0000_A5A5;
        m_ack = ack; m_rdata = rd;
    endtask

    // Mid-cycle: outputs follow whichever port currently owns the bus.
    task automatic settle(input string tag);
        logic          e_cyc, e_stb, e_we, e_iack, e_dack;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        #3;
        e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_iack = 0; e_dack = 0;
        if (owner == 1) begin
            e_cyc = i_cyc; e_stb = i_stb; e_we = i_we; e_addr = i_addr; e_wdata = i_wdata; e_iack = m_ack;
        end else if (owner == 2) begin
            e_cyc = d_cyc; e_stb = d_stb; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_dack = m_ack;
        end
        chk({tag, ".m_cyc"},   64'(m_cyc),   64'(e_cyc));
        chk({tag, ".m_stb"},   64'(m_stb),   64'(e_stb));
        chk({tag, ".m_we"},    64'(m_we),    64'(e_we));
        chk({tag, ".m_addr"},  64'(m_addr),  64'(e_addr));
        chk({tag, ".m_wdata"}, 64'(m_wdata), 64'(e_wdata));
        chk({tag, ".i_ack"},   64'(i_ack),   64'(e_iack));
        chk({tag, ".d_ack"},   64'(d_ack),   64'(e_dack));
        chk({tag, ".i_rdata"}, 64'(i_rdata), 64'(m_rdata));
        chk({tag, ".d_rdata"}, 64'(d_rdata), 64'(m_rdata));
        if (i_ack === 1'b1) iack_cnt++;
    endtask

    // Clock edge: ownership is released on ack or abort, otherwise taken by a requester.
    task automatic edge_step();
        bit ri, rd;
        @(posedge clk);
        if (!rst_n) begin
            owner = 0; last = 2;
        end else if (owner != 0) begin
            if (m_ack || !((owner == 1) ? i_cyc : d_cyc)) owner = 0;
        end else begin
            ri = i_cyc && i_stb;
            rd = d_cyc && d_stb;
            if (ri && rd) begin
`ifdef ARB_ROUND_ROBIN_EN
                owner = (last == 1) ? 2 : 1;
`else
                owner = 2;
`endif
            end else if (ri) owner = 1;
            else if (rd) owner = 2;
            if (owner != 0) last = owner;
        end
        #1;
    endtask

    initial begin
        logic [AW-1:0] exp_order [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{32'h2000, 32'h0, 32'h2000, 32'h0};
`else
        exp_order = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
`endif
        rst_n = 1'b0;
        drv(0, 0, 0, '0, 0, 0, 0, '0, 0, '0);
        @(posedge clk); #1;
        settle("reset");
        edge_step();
        rst_n = 1'b1;

        // Single instruction read with a two-cycle slave.
        iack_cnt = 0;
        drv(1, 1, 0, 32'h100, 0, 0, 0, '0, 0, '0);
        settle("r028_req");
        chk("r028_latency", 64'(m_cyc), 64'(0));
        edge_step();
        settle("r028_g1");
        chk("r028_addr", 64'(m_addr), 64'h100);
        edge_step();
        settle("r028_g2");
        edge_step();
        drv(1, 1, 0, 32'h100, 0, 0, 0, '0, 1, 32'hDEADBEEF);
        settle("r028_ack");
        chk("r028_rdata", 64'(i_rdata), 64'hDEADBEEF);
        chk("r028_dack", 64'(d_ack), 64'(0));
        edge_step();
        drv(0, 0, 0, '0, 0, 0, 0, '0, 0, '0);
        settle("r028_done");
        edge_step();
        chk("r028_pulses", 64'(iack_cnt), 64'(1));

        // Simultaneous requests: data port first, then a turnaround, then instruction.
        drv(1, 1, 0, 32'h0, 1, 1, 1, 32'h2000, 0, '0);
        settle("r029_tie");
        edge_step();
        drv(1, 1, 0, 32'h0, 1, 1, 1, 32'h2000, 1, 32'h1111);
        settle("r029_d");
        chk("r029_first", 64'(m_addr), 64'h2000);
        edge_step();
        drv(1, 1, 0, 32'h0, 0, 0, 0, '0, 0, '0);
        settle("r029_turn");
        chk("r029_turnaround", 64'(m_cyc), 64'(0));
        edge_step();
        drv(1, 1, 0, 32'h0, 0, 0, 0, '0, 1, 32'h2222);
        settle("r029_i");
        chk("r029_second", 64'(m_addr), 64'h0);
        chk("r029_second_cyc", 64'(m_cyc), 64'(1));
        edge_step();

        // Both ports request continuously for four transactions.
        for (int k = 0; k < 4; k++) begin
            drv(1, 1, 0, 32'h0, 1, 1, 0, 32'h2000, 0, '0);
            settle("r030_idle");
            edge_step();
            drv(1, 1, 0, 32'h0, 1, 1, 0, 32'h2000, 1, 32'(k));
            settle("r030_gnt");
            chk($sformatf("r030_order%0d", k), 64'(m_addr), 64'(exp_order[k]));
            edge_step();
        end
        drv(0, 0, 0, '0, 0, 0, 0, '0, 0, '0);
        settle("r030_end");
        edge_step();

        // Data port aborts one cycle into its grant; the late ack must not reach it.
        drv(0, 0, 0, '0, 1, 1, 0, 32'h40, 0, '0);
        settle("r031_req");
        edge_step();
        settle("r031_gnt");
        chk("r031_granted", 64'(m_cyc), 64'(1));
        edge_step();
        drv(0, 0, 0, '0, 0, 1, 0, 32'h40, 0, '0);
        settle("r031_abort");
        chk("r031_cyc_drop", 64'(m_cyc), 64'(0));
        edge_step();
        drv(0, 0, 0, '0, 0, 0, 0, '0, 1, 32'h77);
        settle("r031_late");
        chk("r031_dack", 64'(d_ack), 64'(0));
        edge_step();

        // Stray ack with nothing granted.
        drv(0, 0, 0, '0, 0, 0, 0, '0, 1, 32'h99);
        settle("r033_stray");
        chk("r033_iack", 64'(i_ack), 64'(0));
        chk("r033_dack", 64'(d_ack), 64'(0));
        edge_step();
        drv(0, 0, 0, '0, 0, 0, 0, '0, 0, '0);
        settle("r033_idle");
        chk("r033_still_idle", 64'(m_cyc), 64'(0));
        edge_step();

        // Reset asserted in the middle of an instruction write.
        drv(1, 1, 1, 32'h500, 0, 0, 0, '0, 0, '0);
        settle("r032_req");
        edge_step();
        settle("r032_gnt");
        chk("r032_we", 64'(m_we), 64'(1));
        rst_n = 1'b0;
        m_ack = 1'b1;
        #1;
        chk("r032_cyc_rst", 64'(m_cyc), 64'(0));
        chk("r032_we_rst",  64'(m_we),  64'(0));
        chk("r032_iack_rst", 64'(i_ack), 64'(0));
        edge_step();
        rst_n = 1'b1;
        drv(0, 0, 0, '0, 1, 1, 0, 32'h3000, 0, '0);
        settle("r032_after");
        edge_step();
        drv(0, 0, 0, '0, 1, 1, 0, 32'h3000, 1, 32'h5);
        settle("r032_dgnt");
        chk("r032_first_d", 64'(m_addr), 64'h3000);
        edge_step();

        // Random traffic against the ownership model.
        for (int n = 0; n < 400; n++) begin
            drv(($urandom % 4) != 0, ($urandom % 3) != 0, 1'($urandom), $urandom,
                ($urandom % 4) != 0, ($urandom % 3) != 0, 1'($urandom), $urandom,
                ($urandom % 3) == 0, $urandom);
            settle("rand");
            edge_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2to1.md
BUS_ARBITER_2TO1 -- requirements
Module: bus_arbiter_2to1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data width of all ports.
REQ-003 SHALL have port clk  input  1  the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have instruction-port inputs: i_cyc 1, i_stb 1, i_we 1, i_addr ADDR_WIDTH, i_wdata DATA_WIDTH.
REQ-006 SHALL have instruction-port outputs: i_rdata DATA_WIDTH, i_ack 1.
REQ-007 SHALL have data-port inputs: d_cyc 1, d_stb 1, d_we 1, d_addr ADDR_WIDTH, d_wdata DATA_WIDTH.
REQ-008 SHALL have data-port outputs: d_rdata DATA_WIDTH, d_ack 1.
REQ-009 SHALL have master outputs m_cyc 1, m_stb 1, m_we 1, m_addr ADDR_WIDTH, m_wdata DATA_WIDTH.
REQ-010 SHALL have master inputs m_rdata DATA_WIDTH, m_ack 1.

Function
REQ-011 SHALL implement an FSM with states IDLE, GNT_I and GNT_D.
REQ-012 In IDLE, a port SHALL be requesting when its cyc & stb = 1; the FSM SHALL move to the selected grant state on the next edge, giving 1 cycle of arbitration latency.
REQ-013 With no request in IDLE, the FSM SHALL remain in IDLE; all m_* outputs SHALL be 0.
REQ-014 In GNT_x, m_cyc, m_stb, m_we, m_addr and m_wdata SHALL equal port x's signals combinationally; the non-granted port's signals SHALL be ignored.
REQ-015 m_rdata SHALL be routed to both i_rdata and d_rdata; x_ack SHALL equal m_ack only in GNT_x, else 0.
REQ-016 On m_ack = 1 in GNT_x, the FSM SHALL return to IDLE, with one idle turnaround cycle before any next grant.
REQ-017 If the granted port drops cyc before m_ack (abort), the FSM SHALL return to IDLE on that edge; m_cyc SHALL fall in the same cycle; a late m_ack SHALL be discarded.
REQ-018 A grant SHALL never be preempted; a competing request SHALL wait, held by its requester, until IDLE.
REQ-019 A simultaneous i and d request in IDLE SHALL be resolved per REQ-024/REQ-025.
REQ-020 m_ack while in IDLE SHALL be ignored (no x_ack, no state change).

Reset
REQ-021 Asserting rst_n = 0 SHALL immediately force IDLE, last_grant = D, and all m_* and x_ack to 0, even mid-transaction.
REQ-022 After rst_n rises, the first grant decision SHALL occur on the first edge with a request.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-024 With ARB_ROUND_ROBIN_EN defined, on a tie the port not in last_grant SHALL win; last_grant SHALL update on each grant entry.
REQ-025 With ARB_ROUND_ROBIN_EN undefined, the data port SHALL always win ties (fixed priority); last_grant SHALL be omitted.

Structure
REQ-026 Package arb_pkg SHALL hold the FSM state enum (IDLE/GNT_I/GNT_D) and the port-id enum (PORT_I/PORT_D).
REQ-027 The block SHALL be a single module with no sub-module; the grant select is an inline function.

Verification
REQ-028 Single i read: i_cyc=i_stb=1, i_addr=0x100, m_ack after 2 cycles with m_rdata=0xDEADBEEF -> m_addr=0x100 one cycle after request, i_rdata=0xDEADBEEF, one i_ack pulse, d_ack=0.
REQ-029 Tie, fixed priority: both request in IDLE, i_addr=0x0, d_addr=0x2000 -> first m_addr=0x2000; after ack plus one idle cycle, m_addr=0x0.
REQ-030 Tie with ARB_ROUND_ROBIN_EN: both ports request continuously for 4 transactions -> grant order D,I,D,I.
REQ-031 Abort: d_cyc dropped 1 cycle after grant, then m_ack=1 -> m_cyc=0 in the same cycle, d_ack never asserted, FSM in IDLE.
REQ-032 Reset mid-write: rst_n=0 during GNT_I with i_we=1 -> m_cyc=m_we=0 immediately; after release, a new d request is granted first.
REQ-033 Stray ack: m_ack=1 in IDLE -> i_ack=d_ack=0, state stays IDLE.
